// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane
// geometry and the alignment rule used to reject a request at acceptance.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } mem_state_e;

  localparam int          LANE_W    = 8;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  // A request faults if its size is illegal or its address is not naturally aligned.
  function automatic logic access_fault(input mem_size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends a load lane, and merges
// store data into the surrounding word for read-modify-write.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_sh   = {addr_lo_i, 3'b000};
  assign half_sh   = {addr_lo_i[1], 4'b0000};
  assign byte_lane = rdata_i[byte_sh +: LANE_W];
  assign half_lane = rdata_i[half_sh +: 2*LANE_W];

  always_comb begin
    load_o  = rdata_i;
    merge_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o  = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
        merge_o = (rdata_i & ~(BYTE_MASK << byte_sh)) | ({24'h0, wdata_i[7:0]} << byte_sh);
      end
      SIZE_HALF: begin
        load_o  = {{16{~unsigned_i & half_lane[15]}}, half_lane};
        merge_o = (rdata_i & ~(HALF_MASK << half_sh)) | ({16'h0, wdata_i} << half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit: accepts one request at a time, drives a word-indexed
// data memory, does read-modify-write for sub-word stores, pulses a response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       Write_data,
  input  logic [31:0]       Read_Data,
  output mem_state_e        dbg_state
);

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE, responses cannot be stalled.

  mem_state_e        state_q;
  logic              write_q;
  mem_size_e         size_q;
  logic              unsigned_q;
  logic [1:0]        addr_lo_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] address_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [31:0]       write_data_q;
  logic              resp_valid_q;
  logic              resp_error_q;
  logic [31:0]       resp_rdata_q;

  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  mem_size_e         req_size_e;

  assign req_size_e = mem_size_e'(req_size);

  mem_lane_align u_lane_align (
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .addr_lo_i  (addr_lo_q),
    .rdata_i    (Read_Data),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      size_q       <= SIZE_BYTE;
      unsigned_q   <= 1'b0;
      addr_lo_q    <= 2'b00;
      wdata_q      <= '0;
      address_q    <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      write_data_q <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      // Strobes and response fields are single-cycle; each state re-asserts its own.
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      write_data_q <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size_e;
            unsigned_q <= req_unsigned;
            addr_lo_q  <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
            address_q  <= req_addr >> 2;
            if (access_fault(req_size_e, req_addr[1:0])) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else if (req_write && (req_size_e == SIZE_WORD)) begin
              state_q      <= ST_WRITE;
              mem_write_q  <= 1'b1;
              write_data_q <= req_wdata;
            end else begin
              state_q    <= ST_READ;
              mem_read_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (write_q) begin
            state_q      <= ST_WRITE;
            mem_write_q  <= 1'b1;
            write_data_q <= merge_data;
          end else begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data;
          end
        end
        ST_WRITE: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign Address    = address_q;
  assign Write_data = write_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset abort,
// back-to-back timing, then random requests against a byte-addressed model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int ADDR_W = 32;

  logic              clock;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       Write_data;
  logic [31:0]       Read_Data = 32'h0;
  mem_state_e        dbg_state;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Address      (Address),
    .Write_data   (Write_data),
    .Read_Data    (Read_Data),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_data = 32'h0;

  always @(negedge clock) begin
    if (pre_we)   mem[pre_idx] <= pre_data;
    if (MemRead)  Read_Data <= mem[Address[5:0]];
    if (MemWrite) mem[Address[5:0]] <= Write_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (byte-addressed memory) ----------------
  logic [7:0] exp_bytes [256];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
    int          addr_bad;
    int          both;
  } resp_t;

  function automatic logic [31:0] exp_word(input int widx);
    return {exp_bytes[widx*4+3], exp_bytes[widx*4+2], exp_bytes[widx*4+1], exp_bytes[widx*4]};
  endfunction

  function automatic resp_t model_req(input logic w, input logic [1:0] sz, input logic u,
                                      input logic [31:0] a, input logic [31:0] wd);
    resp_t e;
    int nbytes;
    int ai;
    logic [31:0] val;
    e.rdata = 0; e.err = 0; e.lat = 0; e.nrd = 0; e.nwr = 0; e.wd = 0; e.addr_bad = 0; e.both = 0;
    ai = int'(a);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.err = (sz == 2'd3) || ((ai % nbytes) != 0);
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    if (!w) begin
      val = 0;
      for (int i = 0; i < nbytes; i++) val = val | ({24'h0, exp_bytes[ai+i]} << (8*i));
      if (!u && nbytes < 4 && val >= (32'd1 << (8*nbytes-1))) val = val - (32'd1 << (8*nbytes));
      e.rdata = val;
      e.lat = 2;
      e.nrd = 1;
    end else begin
      for (int i = 0; i < nbytes; i++) exp_bytes[ai+i] = wd[8*i +: 8];
      e.wd  = exp_word(ai / 4);
      e.lat = (nbytes == 4) ? 2 : 3;
      e.nrd = (nbytes == 4) ? 0 : 1;
      e.nwr = 1;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pre_we = 1'b1;
    pre_idx = idx[5:0];
    pre_data = d;
    for (int b = 0; b < 4; b++) exp_bytes[idx*4+b] = d[8*b +: 8];
    @(negedge clock);
    #1 pre_we = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!req_ready && k < 10) begin
      @(negedge clock);
      k++;
    end
    if (!req_ready) check({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  // Issue one request from a negedge and watch it until resp_valid (bounded).
  task automatic do_req(input string name, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, output resp_t r);
    wait_ready(name);
    r.rdata = 32'hxxxx_xxxx; r.err = 1'bx; r.lat = 0; r.nrd = 0; r.nwr = 0;
    r.wd = 0; r.addr_bad = 0; r.both = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      if (MemRead) r.nrd++;
      if (MemWrite) begin
        r.nwr++;
        r.wd = Write_data;
      end
      if (MemRead && MemWrite) r.both++;
      if (Address !== (a >> 2)) r.addr_bad++;
      if (resp_valid) begin
        r.lat = n;
        r.rdata = resp_rdata;
        r.err = resp_error;
        break;
      end
    end
  endtask

  task automatic compare_resp(input string name, input resp_t got, input resp_t exp, input logic w);
    check({name, "_lat"},  32'(got.lat), 32'(exp.lat));
    check({name, "_err"},  32'(got.err), 32'(exp.err));
    check({name, "_nrd"},  32'(got.nrd), 32'(exp.nrd));
    check({name, "_nwr"},  32'(got.nwr), 32'(exp.nwr));
    check({name, "_both"}, 32'(got.both), 32'd0);
    check({name, "_addr"}, 32'(got.addr_bad), 32'd0);
    if (!exp.err) check({name, "_rdata"}, got.rdata, w ? 32'h0 : exp.rdata);
    if (exp.nwr > 0) check({name, "_wd"}, got.wd, exp.wd);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    resp_t r;
    resp_t e;
    resp_t m;
    int acc1, acc2, rsp1;
    int seen;
    logic [31:0] b2b_rdata;
    logic w;
    logic [1:0] sz;
    logic u;
    logic [31:0] a;
    logic [31:0] wd;

    //           w     sz     u     addr    wdata         rdata         err   lat nrd nwr exp_wd
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2, 1, 0, 32'h0};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, 32'h0,        1'b0, 3, 1, 1, 32'hDEAD55EF};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 2, 1, 0, 32'h0};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234, 32'h0,        1'b0, 3, 1, 1, 32'h123455EF};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'h0};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h00005678, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[12] = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h000055EF, 1'b0, 2, 1, 0, 32'h0};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFFA7, 32'h0,        1'b0, 3, 1, 1, 32'hA73455EF};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFFA7, 1'b0, 2, 1, 0, 32'h0};

    // ---- reset ----
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    check("rst_ready",      32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_memread",    32'(MemRead), 32'd0);
    check("rst_memwrite",   32'(MemWrite), 32'd0);
    check("rst_address",    Address, 32'h0);
    check("rst_write_data", Write_data, 32'h0);
    check("rst_state",      32'(dbg_state), 32'(ST_IDLE));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // ---- directed table ----
    for (int i = 0; i < 15; i++) begin
      do_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, tbl[i].wd, r);
      m = model_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, tbl[i].wd);
      e.rdata = tbl[i].rdata; e.err = tbl[i].err; e.lat = tbl[i].lat; e.nrd = tbl[i].nrd;
      e.nwr = tbl[i].nwr; e.wd = tbl[i].exp_wd; e.addr_bad = 0; e.both = 0;
      compare_resp($sformatf("vec%0d", i), r, e, tbl[i].w);
    end
    check("vec_word4_final", mem[4], 32'hA73455EF);

    // ---- reset during WRITE of a word store ----
    @(negedge clock);
    preload(8, 32'h11111111);
    wait_ready("rstw");
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1 req_valid = 1'b0;
    check("rstw_memwrite_on", 32'(MemWrite), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rstw_memwrite_off", 32'(MemWrite), 32'd0);
    check("rstw_ready",        32'(req_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    check("rstw_no_resp", 32'(seen), 32'd0);
    check("rstw_word8",   mem[8], 32'h11111111);

    // ---- back-to-back with req_valid held high ----
    wait_ready("b2b");
    m = model_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    acc1 = -1; acc2 = -1; rsp1 = -1; b2b_rdata = 32'h0;
    for (int k = 0; k < 12; k++) begin
      if (req_ready && req_valid) begin
        if (acc1 < 0) acc1 = k;
        else if (acc2 < 0) acc2 = k;
      end
      if (resp_valid && rsp1 < 0) begin
        rsp1 = k;
        b2b_rdata = resp_rdata;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);
    check("b2b_resp_lat",   32'(rsp1 - acc1), 32'd2);
    check("b2b_rdata",      b2b_rdata, m.rdata);

    // ---- randomized requests against the model ----
    for (int i = 0; i < 150; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      do_req($sformatf("rnd%0d", i), w, sz, u, a, wd, r);
      m = model_req(w, sz, u, a, wd);
      compare_resp($sformatf("rnd%0d", i), r, m, w);
    end
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 64; i++) check($sformatf("mem_word%0d", i), mem[i], exp_word(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The unit SHALL have parameter ADDR_W, default 32, meaning the width of the byte address and of the memory-side Address.
REQ-002 The unit SHALL have port clock, input, 1, meaning the single system clock; all state updates on posedge.
REQ-003 The unit SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-004 The unit SHALL have port req_valid, input, 1, meaning the CPU presents a load/store request.
REQ-005 The unit SHALL have port req_ready, output, 1, meaning the unit can accept a request this cycle.
REQ-006 The unit SHALL have port req_write, input, 1, meaning 1=store, 0=load.
REQ-007 The unit SHALL have port req_size, input, 2, meaning 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The unit SHALL have port req_unsigned, input, 1, meaning zero-extend load when 1, sign-extend when 0.
REQ-009 The unit SHALL have port req_addr, input, ADDR_W, meaning the byte address.
REQ-010 The unit SHALL have port req_wdata, input, 32, meaning store data, right-aligned.
REQ-011 The unit SHALL have port resp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-012 The unit SHALL have port resp_rdata, output, 32, meaning extended load data (0 for stores).
REQ-013 The unit SHALL have port resp_error, output, 1, meaning misaligned or illegal-size request; valid with resp_valid.
REQ-014 The unit SHALL have ports MemRead (output, 1), MemWrite (output, 1), Address (output, ADDR_W; word index) and Write_data (output, 32) driving the data memory, plus Read_Data (input, 32) returned by the memory.

Function
REQ-015 The unit SHALL implement FSM states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 exactly in IDLE.
REQ-016 The unit SHALL accept a request on a posedge with req_valid&&req_ready and register all req_* fields at that edge.
REQ-017 Address SHALL be req_addr>>2, zero-extended and held constant from acceptance until return to IDLE.
REQ-018 Alignment rules: half requires addr[0]=0, word requires addr[1:0]=0, size 11 is illegal; a violating request SHALL go IDLE->RESP with resp_error=1 and no MemRead/MemWrite activity.
REQ-019 A load SHALL follow IDLE->READ->RESP, with MemRead=1 for exactly the READ cycle; Read_Data is sampled at the posedge ending READ (memory updates on the preceding negedge).
REQ-020 A word store SHALL follow IDLE->WRITE->RESP, with MemWrite=1 and Write_data=req_wdata for exactly the WRITE cycle.
REQ-021 A byte/half store SHALL follow IDLE->READ->WRITE->RESP as read-modify-write: the target lane(s) are replaced by req_wdata[7:0] or [15:0] and the other lanes keep the read value.
REQ-022 Lanes SHALL be little-endian: addr[1:0]=0 selects bits 7:0 and addr[1:0]=3 selects bits 31:24; the half at addr[1]=1 is bits 31:16.
REQ-023 Loads SHALL extract the lane and extend it to 32 bits per req_unsigned; a word load returns Read_Data unchanged.
REQ-024 resp_valid SHALL be 1 only in RESP (one cycle); RESP SHALL always go to IDLE; there is no response backpressure.
REQ-025 Latency: resp_valid SHALL assert 2 cycles after acceptance for loads and word stores, 3 cycles for sub-word stores, and 1 cycle for errors.
REQ-026 MemRead and MemWrite SHALL never be 1 in the same cycle; both SHALL be 0 in IDLE and RESP.

Reset
REQ-027 While reset_n=0: state=IDLE, req_ready=1, and resp_valid, resp_error, resp_rdata, MemRead, MemWrite, Address and Write_data = 0.
REQ-028 A reset mid-operation SHALL abort the request immediately (asynchronously deasserting MemWrite so that no write lands), with no resp_valid for it.

Structure
REQ-029 The size encodings, FSM state encodings and lane constants SHALL live in shared package mem_access_pkg.
REQ-030 Lane extract/merge and extension logic SHALL be a combinational sub-module mem_lane_align.

Verification
REQ-031 The bench SHALL cover: sw addr 0x10 data 0xDEADBEEF -> Address=4, MemWrite for 1 cycle, Write_data=0xDEADBEEF, resp_valid 2 cycles after accept, resp_error=0.
REQ-032 The bench SHALL cover: lb addr 0x13 with word4=0xDEADBEEF -> resp_rdata=0xFFFFFFDE; lbu -> 0x000000DE; lhu addr 0x12 -> 0x0000DEAD.
REQ-033 The bench SHALL cover: sb addr 0x11 data 0x55 with word4=0xDEADBEEF -> a MemRead cycle, then a MemWrite cycle with 0xDEAD55EF, and resp_valid 3 cycles after accept.
REQ-034 The bench SHALL cover: lw addr 0x12 -> resp_error=1 one cycle after accept, with MemRead=MemWrite=0 throughout.
REQ-035 The bench SHALL cover: reset_n low during WRITE of sw 0x20 -> MemWrite drops immediately, word8 is unchanged, no resp_valid, and req_ready=1.
REQ-036 The bench SHALL cover: back-to-back requests with req_valid held high -> the second is accepted on the cycle after the first's RESP.
